dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
- In-order dual-issue controller between the two decode slots (ds1, ds2) and the two execute stages (es1, es2).
- Decides each cycle which decoded instructions may issue, and generates the execute clock-enables es1_o_ce / es2_o_ce.
- Tracks outstanding destination registers in a scoreboard, cleared by commit writebacks cd1/cd2.
- Arbitrates the single shared multi-cycle mul/div unit (MD) between the slots.

Parameters:
- REG_AW, 5, register address width.
- NUM_REGS, 32, scoreboard depth (2**REG_AW).
- MD_LAT, 4, MD unit busy cycles after issue; legal range 1..15.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- ds1_i_valid  in  1  slot 1 (older) holds an instruction.
- ds1_i_rs, ds1_i_rt  in  REG_AW  slot 1 source registers.
- ds1_i_rd  in  REG_AW  slot 1 destination register.
- ds1_i_we  in  1  slot 1 writes rd.
- ds1_i_md  in  1  slot 1 needs the MD unit.
- ds2_i_*  in  same  slot 2 (younger) equivalents.
- cd1_i_we, cd2_i_we  in  1  commit writeback strobes.
- cd1_i_rd, cd2_i_rd  in  REG_AW  commit destination registers.
- ds1_o_ack, ds2_o_ack  out  1  combinational; slot issues this cycle.
- es1_o_ce, es2_o_ce  out  1  registered; ce for es1/es2, one cycle after the matching ack.
- o_md_busy  out  1  MD unit occupied.

Behaviour:
- Reset (async, i_rst=1):
  - scoreboard all 0, MD counter 0, FSM MD_IDLE.
  - es1_o_ce = es2_o_ce = 0, o_md_busy = 0.
  - acks are 0 because reset gates them.
- Scoreboard (sb[NUM_REGS]):
  - Bit set on issue of an instruction with we=1 and rd!=0.
  - Bit cleared on cd*_i_we with cd*_i_rd.
  - Register 0 is never set.
  - Same-cycle set and clear of the same register: set wins.
  - Hazard checks use the bypassed view: sb minus this cycle's commit clears.
- Slot 1 issues (ds1_o_ack=1) iff all of:
  - ds1_i_valid.
  - No bypassed-sb hit on rs, rt, or on rd when we=1 (WAW).
  - If ds1_i_md: MD FSM is MD_IDLE.
- Slot 2 issues iff all of:
  - ds1_o_ack=1; in-order, so slot 2 never issues alone.
  - ds2_i_valid and its own sb checks pass.
  - No intra-pair RAW: ds1_i_we, ds1_i_rd!=0, and ds1_i_rd equal to ds2 rs or rt.
  - No intra-pair WAW: both we=1 with equal rd!=0.
  - Not both ds1_i_md and ds2_i_md (structural hazard).
  - If ds2_i_md: MD FSM is MD_IDLE.
- Non-accepted slots: decode holds them. Shifting slot 2 into slot 1 is decode's job.
- es*_o_ce: es1_o_ce <= ds1_o_ack and es2_o_ce <= ds2_o_ack. Latency is exactly 1 cycle.
- MD FSM:
  - MD_IDLE to MD_BUSY on issue of an md instruction; counter loads MD_LAT-1.
  - MD_BUSY: counter decrements; at 0 go to MD_IDLE.
  - o_md_busy = (state==MD_BUSY).
  - An md instruction may issue in the cycle the FSM returns to MD_IDLE.
- Commit on a register not set in sb: no effect, no error.

Optional Feature:
- SCHED_PERF_EN defined:
  - Adds outputs o_stall_raw_cnt, o_stall_md_cnt, o_dual_cnt (32 bits each, saturating, reset to 0).
  - o_stall_raw_cnt counts cycles where ds1_i_valid is blocked by a scoreboard hit.
  - o_stall_md_cnt counts cycles where slot 1 is blocked by the MD unit.
  - o_dual_cnt counts cycles with both acks high.
- SCHED_PERF_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: REG_AW, NUM_REGS, MD_LAT defaults, and MD FSM state encodings (MD_IDLE=0, MD_BUSY=1).
- One sub-module, sched_scoreboard: set/clear vector, bypassed read, and 3-port hazard lookup per slot.
- Issue logic, MD FSM and ce registers stay in the top module.

Test Plan:
- Independent pair: ds1 add r3←r1,r2; ds2 add r5←r4,r6, sb empty → both acks same cycle; es1_o_ce=es2_o_ce=1 next cycle; sb[3]=sb[5]=1.
- Intra-pair RAW: ds1 writes r3; ds2 reads r3 → ds1_o_ack=1, ds2_o_ack=0; es1_o_ce=1, es2_o_ce=0 next cycle.
- Scoreboard stall and bypass:
  - sb[7]=1 and ds1 reads r7 → no ack.
  - Assert cd1_i_we with cd1_i_rd=7 → ds1_o_ack=1 in that same cycle.
- MD contention: md op issued at t0 (MD_LAT=4); second md op waits.
  - o_md_busy=1 for cycles t1..t4.
  - Second md op acked in the cycle the FSM returns to MD_IDLE.
  - Both slots md in one cycle → only slot 1 acks.
- Register 0 and reset:
  - Issue a write to r0 → sb unchanged.
  - Assert i_rst asynchronously mid-MD_BUSY → o_md_busy, es*_o_ce and sb clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dual_issue_scheduler_pkg.sv
// Shared defaults and MD-unit state encoding for the dual-issue scheduler.
package dual_issue_scheduler_pkg;

  localparam int REG_AW_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int MD_LAT_DEF   = 4;
  localparam int MD_CNT_W     = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Counter preload so that the unit reads busy for exactly lat cycles.
  function automatic logic [MD_CNT_W-1:0] md_load(input int lat);
    return MD_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/sched_scoreboard.sv
// Outstanding-destination scoreboard: set on issue, clear on commit,
// with commit-bypassed hazard lookup for both decode slots.
module sched_scoreboard
  import dual_issue_scheduler_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              set1_en,
  input  logic [REG_AW-1:0] set1_rd,
  input  logic              set2_en,
  input  logic [REG_AW-1:0] set2_rd,
  input  logic              clr1_en,
  input  logic [REG_AW-1:0] clr1_rd,
  input  logic              clr2_en,
  input  logic [REG_AW-1:0] clr2_rd,
  input  logic [REG_AW-1:0] s1_rs,
  input  logic [REG_AW-1:0] s1_rt,
  input  logic [REG_AW-1:0] s1_rd,
  input  logic              s1_we,
  input  logic [REG_AW-1:0] s2_rs,
  input  logic [REG_AW-1:0] s2_rt,
  input  logic [REG_AW-1:0] s2_rd,
  input  logic              s2_we,
  output logic              s1_hit,
  output logic              s2_hit
);

  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] sb_byp;

  // Register 0 is hard-wired, so it is never allowed into the set mask.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr1_en) clr_mask[clr1_rd] = 1'b1;
    if (clr2_en) clr_mask[clr2_rd] = 1'b1;
    if (set1_en && (set1_rd != '0)) set_mask[set1_rd] = 1'b1;
    if (set2_en && (set2_rd != '0)) set_mask[set2_rd] = 1'b1;
  end

  assign sb_byp = sb & ~clr_mask;

  assign s1_hit = sb_byp[s1_rs] | sb_byp[s1_rt] | (s1_we & sb_byp[s1_rd]);
  assign s2_hit = sb_byp[s2_rs] | sb_byp[s2_rt] | (s2_we & sb_byp[s2_rd]);

  // Set is applied after clear so a same-cycle set wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sb <= '0;
    else       sb <= sb_byp | set_mask;
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue controller: hazard-gated acks, MD-unit arbitration, execute CEs.
// Optional performance counters are built when SCHED_PERF_EN is defined.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int MD_LAT   = MD_LAT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              ds1_i_valid,
  input  logic [REG_AW-1:0] ds1_i_rs,
  input  logic [REG_AW-1:0] ds1_i_rt,
  input  logic [REG_AW-1:0] ds1_i_rd,
  input  logic              ds1_i_we,
  input  logic              ds1_i_md,
  input  logic              ds2_i_valid,
  input  logic [REG_AW-1:0] ds2_i_rs,
  input  logic [REG_AW-1:0] ds2_i_rt,
  input  logic [REG_AW-1:0] ds2_i_rd,
  input  logic              ds2_i_we,
  input  logic              ds2_i_md,
  input  logic              cd1_i_we,
  input  logic [REG_AW-1:0] cd1_i_rd,
  input  logic              cd2_i_we,
  input  logic [REG_AW-1:0] cd2_i_rd,
  output logic              ds1_o_ack,
  output logic              ds2_o_ack,
  output logic              es1_o_ce,
  output logic              es2_o_ce,
  output logic              o_md_busy
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]       o_stall_raw_cnt,
  output logic [31:0]       o_stall_md_cnt,
  output logic [31:0]       o_dual_cnt
`endif
);

  md_state_e             md_state, md_state_nxt;
  logic [MD_CNT_W-1:0]   md_cnt, md_cnt_nxt;
  logic                  hit1, hit2;
  logic                  md_free;
  logic                  raw_pair, waw_pair;
  logic                  md_issue;

  sched_scoreboard #(
    .REG_AW   (REG_AW),
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .set1_en (ds1_o_ack & ds1_i_we),
    .set1_rd (ds1_i_rd),
    .set2_en (ds2_o_ack & ds2_i_we),
    .set2_rd (ds2_i_rd),
    .clr1_en (cd1_i_we),
    .clr1_rd (cd1_i_rd),
    .clr2_en (cd2_i_we),
    .clr2_rd (cd2_i_rd),
    .s1_rs   (ds1_i_rs),
    .s1_rt   (ds1_i_rt),
    .s1_rd   (ds1_i_rd),
    .s1_we   (ds1_i_we),
    .s2_rs   (ds2_i_rs),
    .s2_rt   (ds2_i_rt),
    .s2_rd   (ds2_i_rd),
    .s2_we   (ds2_i_we),
    .s1_hit  (hit1),
    .s2_hit  (hit2)
  );

  assign md_free  = (md_state == MD_IDLE);
  assign raw_pair = ds1_i_we && (ds1_i_rd != '0) &&
                    ((ds1_i_rd == ds2_i_rs) || (ds1_i_rd == ds2_i_rt));
  assign waw_pair = ds1_i_we && ds2_i_we && (ds1_i_rd != '0) && (ds1_i_rd == ds2_i_rd);

  // Slot 2 is only considered once the older slot is known to issue.
  assign ds1_o_ack = !i_rst && ds1_i_valid && !hit1 && (!ds1_i_md || md_free);
  assign ds2_o_ack = ds1_o_ack && ds2_i_valid && !hit2 && !raw_pair && !waw_pair &&
                     !(ds1_i_md && ds2_i_md) && (!ds2_i_md || md_free);

  assign md_issue  = (ds1_o_ack && ds1_i_md) || (ds2_o_ack && ds2_i_md);
  assign o_md_busy = (md_state == MD_BUSY);

  always_comb begin
    md_state_nxt = md_state;
    md_cnt_nxt   = md_cnt;
    case (md_state)
      MD_IDLE: begin
        if (md_issue) begin
          md_state_nxt = MD_BUSY;
          md_cnt_nxt   = md_load(MD_LAT);
        end
      end
      MD_BUSY: begin
        if (md_cnt == '0) md_state_nxt = MD_IDLE;
        else              md_cnt_nxt   = md_cnt - MD_CNT_W'(1);
      end
    endcase
  end

  // Stage boundary: issue decision to execute clock-enables and MD state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
      es1_o_ce <= 1'b0;
      es2_o_ce <= 1'b0;
    end else begin
      md_state <= md_state_nxt;
      md_cnt   <= md_cnt_nxt;
      es1_o_ce <= ds1_o_ack;
      es2_o_ce <= ds2_o_ack;
    end
  end

`ifdef SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_raw_cnt <= '0;
      o_stall_md_cnt  <= '0;
      o_dual_cnt      <= '0;
    end else begin
      if (ds1_i_valid && hit1)                o_stall_raw_cnt <= sat_inc(o_stall_raw_cnt);
      if (ds1_i_valid && ds1_i_md && !md_free) o_stall_md_cnt  <= sat_inc(o_stall_md_cnt);
      if (ds1_o_ack && ds2_o_ack)             o_dual_cnt      <= sat_inc(o_dual_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler: directed scenarios plus random traffic
// checked against a queue-fed reference model of the issue rules.
`timescale 1ns/1ps
module tb_dual_issue_scheduler;

  localparam int MD_LAT = 4;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       we;
    logic       md;
  } ins_t;

  typedef struct {
    bit a1;
    bit a2;
    bit c1;
    bit c2;
    bit busy;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       ds1_i_valid, ds1_i_we, ds1_i_md;
  logic [4:0] ds1_i_rs, ds1_i_rt, ds1_i_rd;
  logic       ds2_i_valid, ds2_i_we, ds2_i_md;
  logic [4:0] ds2_i_rs, ds2_i_rt, ds2_i_rd;
  logic       cd1_i_we, cd2_i_we;
  logic [4:0] cd1_i_rd, cd2_i_rd;
  logic       ds1_o_ack, ds2_o_ack, es1_o_ce, es2_o_ce, o_md_busy;
`ifdef SCHED_PERF_EN
  logic [31:0] o_stall_raw_cnt, o_stall_md_cnt, o_dual_cnt;
`endif

  dual_issue_scheduler #(.REG_AW(5), .NUM_REGS(32), .MD_LAT(MD_LAT)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .ds1_i_valid (ds1_i_valid),
    .ds1_i_rs    (ds1_i_rs),
    .ds1_i_rt    (ds1_i_rt),
    .ds1_i_rd    (ds1_i_rd),
    .ds1_i_we    (ds1_i_we),
    .ds1_i_md    (ds1_i_md),
    .ds2_i_valid (ds2_i_valid),
    .ds2_i_rs    (ds2_i_rs),
    .ds2_i_rt    (ds2_i_rt),
    .ds2_i_rd    (ds2_i_rd),
    .ds2_i_we    (ds2_i_we),
    .ds2_i_md    (ds2_i_md),
    .cd1_i_we    (cd1_i_we),
    .cd1_i_rd    (cd1_i_rd),
    .cd2_i_we    (cd2_i_we),
    .cd2_i_rd    (cd2_i_rd),
    .ds1_o_ack   (ds1_o_ack),
    .ds2_o_ack   (ds2_o_ack),
    .es1_o_ce    (es1_o_ce),
    .es2_o_ce    (es2_o_ce),
    .o_md_busy   (o_md_busy)
`ifdef SCHED_PERF_EN
    ,
    .o_stall_raw_cnt (o_stall_raw_cnt),
    .o_stall_md_cnt  (o_stall_md_cnt),
    .o_dual_cnt      (o_dual_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int   total  = 0;
  int   passed = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  // Reference model state: pending-writer flags, remaining MD busy cycles, last acks.
  bit sb_m[32];
  int md_left;
  bit pa1, pa2;

  localparam ins_t NOP = '0;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
  endtask

  function automatic ins_t mk(input bit v, input int rd, input int rs, input int rt,
                              input bit we, input bit md);
    ins_t s;
    s.v = v; s.rd = 5'(rd); s.rs = 5'(rs); s.rt = 5'(rt); s.we = we; s.md = md;
    return s;
  endfunction

  function automatic void model_reset();
    foreach (sb_m[i]) sb_m[i] = 1'b0;
    md_left = 0;
    pa1 = 1'b0;
    pa2 = 1'b0;
  endfunction

  // A register is pending unless a commit this cycle retires it.
  function automatic bit pending(input logic [4:0] r);
    return sb_m[r] && !(cd1_i_we && cd1_i_rd == r) && !(cd2_i_we && cd2_i_rd == r);
  endfunction

  function automatic bit slot_clear(input ins_t s);
    return !pending(s.rs) && !pending(s.rt) && !(s.we && pending(s.rd)) &&
           !(s.md && md_left > 0);
  endfunction

  task automatic idle_inputs();
    {ds1_i_valid, ds1_i_rs, ds1_i_rt, ds1_i_rd, ds1_i_we, ds1_i_md} = NOP;
    {ds2_i_valid, ds2_i_rs, ds2_i_rt, ds2_i_rd, ds2_i_we, ds2_i_md} = NOP;
    cd1_i_we = 1'b0; cd1_i_rd = '0; cd2_i_we = 1'b0; cd2_i_rd = '0;
  endtask

  task automatic drive(input ins_t s1, input ins_t s2, input bit c1w, input int c1r,
                       input bit c2w, input int c2r);
    exp_t e;
    bit ok1, ok2;
    @(posedge i_clk); #1;
    {ds1_i_valid, ds1_i_rs, ds1_i_rt, ds1_i_rd, ds1_i_we, ds1_i_md} = s1;
    {ds2_i_valid, ds2_i_rs, ds2_i_rt, ds2_i_rd, ds2_i_we, ds2_i_md} = s2;
    cd1_i_we = c1w; cd1_i_rd = 5'(c1r); cd2_i_we = c2w; cd2_i_rd = 5'(c2r);
    ok1 = s1.v && slot_clear(s1);
    ok2 = ok1 && s2.v && slot_clear(s2) &&
          !(s1.we && s1.rd != 0 && (s1.rd == s2.rs || s1.rd == s2.rt)) &&
          !(s1.we && s2.we && s1.rd != 0 && s1.rd == s2.rd) &&
          !(s1.md && s2.md);
    e.a1 = ok1; e.a2 = ok2; e.c1 = pa1; e.c2 = pa2; e.busy = (md_left > 0);
    q.push_back(e);
    if (c1w) sb_m[5'(c1r)] = 1'b0;
    if (c2w) sb_m[5'(c2r)] = 1'b0;
    if (ok1 && s1.we && s1.rd != 0) sb_m[s1.rd] = 1'b1;
    if (ok2 && s2.we && s2.rd != 0) sb_m[s2.rd] = 1'b1;
    if ((ok1 && s1.md) || (ok2 && s2.md)) md_left = MD_LAT;
    else if (md_left > 0) md_left--;
    pa1 = ok1;
    pa2 = ok2;
  endtask

  task automatic drive1(input ins_t s1);
    drive(s1, NOP, 1'b0, 0, 1'b0, 0);
  endtask

  always @(negedge i_clk) begin
    if (mon_en && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ds1_ack", ds1_o_ack, e.a1);
      chk("ds2_ack", ds2_o_ack, e.a2);
      chk("es1_ce",  es1_o_ce,  e.c1);
      chk("es2_ce",  es2_o_ce,  e.c2);
      chk("md_busy", o_md_busy, e.busy);
    end
  end

  initial begin
    idle_inputs();
    ds1_i_valid = 1'b1;
    #1;
    chk("rst_ack1_gated", ds1_o_ack, 1'b0);
    chk("rst_ce1", es1_o_ce, 1'b0);
    chk("rst_ce2", es2_o_ce, 1'b0);
    chk("rst_busy", o_md_busy, 1'b0);
    idle_inputs();
    #11 i_rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Independent pair issues together; CEs follow one cycle later.
    drive(mk(1, 3, 1, 2, 1, 0), mk(1, 5, 4, 6, 1, 0), 1'b0, 0, 1'b0, 0);
    @(negedge i_clk);
    chk("pair_ack1", ds1_o_ack, 1'b1);
    chk("pair_ack2", ds2_o_ack, 1'b1);
    drive1(NOP);
    @(negedge i_clk);
    chk("pair_ce1", es1_o_ce, 1'b1);
    chk("pair_ce2", es2_o_ce, 1'b1);
    drive1(mk(1, 0, 3, 5, 0, 0));
    @(negedge i_clk);
    chk("sb3_5_set_stall", ds1_o_ack, 1'b0);

    // Intra-pair RAW.
    drive(mk(1, 9, 1, 2, 1, 0), mk(1, 8, 9, 4, 1, 0), 1'b0, 0, 1'b0, 0);
    @(negedge i_clk);
    chk("raw_ack1", ds1_o_ack, 1'b1);
    chk("raw_ack2", ds2_o_ack, 1'b0);
    drive1(NOP);
    @(negedge i_clk);
    chk("raw_ce1", es1_o_ce, 1'b1);
    chk("raw_ce2", es2_o_ce, 1'b0);

    // Scoreboard stall, then commit bypass in the same cycle.
    drive1(mk(1, 7, 1, 2, 1, 0));
    drive1(mk(1, 14, 7, 1, 1, 0));
    @(negedge i_clk);
    chk("sb_stall", ds1_o_ack, 1'b0);
    drive(mk(1, 14, 7, 1, 1, 0), NOP, 1'b1, 7, 1'b0, 0);
    @(negedge i_clk);
    chk("sb_bypass", ds1_o_ack, 1'b1);

    // MD contention.
    drive1(mk(1, 10, 0, 0, 1, 1));
    @(negedge i_clk);
    chk("md_t0_ack", ds1_o_ack, 1'b1);
    for (int i = 1; i <= MD_LAT; i++) begin
      drive1(mk(1, 11, 0, 0, 1, 1));
      @(negedge i_clk);
      chk("md_wait_ack", ds1_o_ack, 1'b0);
      chk("md_wait_busy", o_md_busy, 1'b1);
    end
    drive1(mk(1, 11, 0, 0, 1, 1));
    @(negedge i_clk);
    chk("md_reissue_ack", ds1_o_ack, 1'b1);
    chk("md_reissue_idle", o_md_busy, 1'b0);
    for (int i = 0; i < MD_LAT; i++) drive1(NOP);
    drive(mk(1, 12, 0, 0, 1, 1), mk(1, 13, 0, 0, 1, 1), 1'b0, 0, 1'b0, 0);
    @(negedge i_clk);
    chk("md_both_ack1", ds1_o_ack, 1'b1);
    chk("md_both_ack2", ds2_o_ack, 1'b0);
    for (int i = 0; i < MD_LAT; i++) drive1(NOP);

    // Writes to r0 never become pending.
    drive1(mk(1, 0, 1, 2, 1, 0));
    drive1(mk(1, 0, 0, 0, 1, 0));
    @(negedge i_clk);
    chk("r0_not_set", ds1_o_ack, 1'b1);

    // Asynchronous reset in the middle of MD_BUSY.
    drive1(mk(1, 15, 0, 0, 1, 1));
    @(negedge i_clk);
    mon_en = 1'b0;
    drive1(mk(1, 20, 1, 2, 1, 0));
    #1;
    chk("pre_rst_busy", o_md_busy, 1'b1);
    chk("pre_rst_ce1", es1_o_ce, 1'b1);
    #1;
    i_rst = 1'b1;
    idle_inputs();
    #1;
    chk("async_rst_busy", o_md_busy, 1'b0);
    chk("async_rst_ce1", es1_o_ce, 1'b0);
    chk("async_rst_ce2", es2_o_ce, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    q.delete();
    model_reset();
    mon_en = 1'b1;
    drive1(mk(1, 0, 10, 15, 0, 0));
    @(negedge i_clk);
    chk("rst_sb_clear", ds1_o_ack, 1'b1);

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      ins_t s1, s2;
      s1 = mk($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      s2 = mk($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      drive(s1, s2, $urandom_range(0, 9) < 4, $urandom_range(0, 7),
            $urandom_range(0, 9) < 4, $urandom_range(0, 7));
    end
    drive1(NOP);
    @(negedge i_clk);
    #1;
    chk("queue_drained", q.size() == 0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
